// File: rtl/pref_issue_queue.sv
// Prefetch issue queue: line-aligns up to three stride-prefetcher candidates per
// cycle, filters duplicates, and issues them to memory in FIFO order.
module pref_issue_queue #(
  parameter int DEPTH     = 8,
  parameter int LINE_BITS = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [63:0]              pref_addr1_i,
  input  logic [63:0]              pref_addr2_i,
  input  logic [63:0]              pref_addr3_i,
  input  logic                     pref_valid1_i,
  input  logic                     pref_valid2_i,
  input  logic                     pref_valid3_i,
  input  logic                     enable_i,
  input  logic                     flush_i,
  output logic                     mem_req_valid_o,
  output logic [63:0]              mem_req_addr_o,
  input  logic                     mem_req_ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [15:0]              drop_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [63:0] LINE_MASK = ~((64'd1 << LINE_BITS) - 64'd1);

  logic [63:0]      entries_q [DEPTH];
  logic [63:0]      entries_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      drop_q, drop_d;
  logic [63:0]      addr_q, addr_d;

  logic [63:0]      cand_addr [3];
  logic [2:0]       cand_elig;
  logic [2:0]       cand_surv;
  logic [DEPTH-1:0] occ;
  logic [PTR_W-1:0] offset;
  logic [CNT_W-1:0] free_slots;
  logic [CNT_W-1:0] n_push;
  logic [1:0]       n_drop;
  logic [16:0]      drop_sum;
  logic             take;
  logic             pop;

  always_comb begin
    cand_addr[0] = pref_addr1_i & LINE_MASK;
    cand_addr[1] = pref_addr2_i & LINE_MASK;
    cand_addr[2] = pref_addr3_i & LINE_MASK;
    take         = enable_i & ~flush_i & ~rst;
    cand_elig    = {pref_valid3_i, pref_valid2_i, pref_valid1_i} & {3{take}};

    // An entry is live when its distance from head is below the occupancy.
    occ    = '0;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - head_q;
      occ[i] = ({1'b0, offset} < count_q);
    end

    cand_surv = cand_elig;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < k; j++) begin
        if (cand_elig[j] && (cand_addr[j] == cand_addr[k])) cand_surv[k] = 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (occ[i] && (entries_q[i] == cand_addr[k])) cand_surv[k] = 1'b0;
      end
    end

    // Free space is judged on start-of-cycle occupancy; a same-cycle pop does not help.
    free_slots = CNT_W'(DEPTH) - count_q;
    n_push     = '0;
    n_drop     = '0;
    entries_d  = entries_q;
    for (int k = 0; k < 3; k++) begin
      if (cand_surv[k]) begin
        if (n_push < free_slots) begin
          entries_d[tail_q + PTR_W'(n_push)] = cand_addr[k];
          n_push = n_push + CNT_W'(1);
        end else begin
          n_drop = n_drop + 2'd1;
        end
      end
    end

    pop      = (count_q != '0) & mem_req_ready_i;
    head_d   = head_q + PTR_W'(pop);
    tail_d   = tail_q + PTR_W'(n_push);
    count_d  = count_q + n_push - CNT_W'(pop);
    drop_sum = {1'b0, drop_q} + 17'(n_drop);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      drop_d  = drop_q;
    end

    // The output register tracks the post-update head so issue stays fully registered.
    addr_d = (count_d != '0) ? entries_d[head_d] : 64'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
      addr_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
      addr_q  <= addr_d;
    end
  end

  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

  assign mem_req_valid_o = (count_q != '0);
  assign mem_req_addr_o  = addr_q;
  assign count_o         = count_q;
  assign drop_cnt_o      = drop_q;

endmodule

// File: tb/tb_pref_issue_queue.sv
// Directed self-checking bench for pref_issue_queue with DEPTH=8, LINE_BITS=6.
module tb_pref_issue_queue;

  logic        clk;
  logic        rst;
  logic [63:0] pref_addr1_i, pref_addr2_i, pref_addr3_i;
  logic        pref_valid1_i, pref_valid2_i, pref_valid3_i;
  logic        enable_i;
  logic        flush_i;
  logic        mem_req_valid_o;
  logic [63:0] mem_req_addr_o;
  logic        mem_req_ready_i;
  logic [3:0]  count_o;
  logic [15:0] drop_cnt_o;

  int checks = 0;
  int errors = 0;

  pref_issue_queue #(.DEPTH(8), .LINE_BITS(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .pref_addr1_i   (pref_addr1_i),
    .pref_addr2_i   (pref_addr2_i),
    .pref_addr3_i   (pref_addr3_i),
    .pref_valid1_i  (pref_valid1_i),
    .pref_valid2_i  (pref_valid2_i),
    .pref_valid3_i  (pref_valid3_i),
    .enable_i       (enable_i),
    .flush_i        (flush_i),
    .mem_req_valid_o(mem_req_valid_o),
    .mem_req_addr_o (mem_req_addr_o),
    .mem_req_ready_i(mem_req_ready_i),
    .count_o        (count_o),
    .drop_cnt_o     (drop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle; inputs are driven and outputs sampled 1 time unit after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cands();
    pref_valid1_i = 1'b0;
    pref_valid2_i = 1'b0;
    pref_valid3_i = 1'b0;
  endtask

  task automatic offer(input logic v1, input logic [63:0] a1,
                       input logic v2, input logic [63:0] a2,
                       input logic v3, input logic [63:0] a3);
    pref_valid1_i = v1; pref_addr1_i = a1;
    pref_valid2_i = v2; pref_addr2_i = a2;
    pref_valid3_i = v3; pref_addr3_i = a3;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (count_o !== 4'd0) begin errors++; $display("[TB] FAIL reset_count got %0d expected 0", count_o); end
    checks++; if (mem_req_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0b expected 0", mem_req_valid_o); end
    checks++; if (mem_req_addr_o !== 64'd0) begin errors++; $display("[TB] FAIL reset_addr got %h expected 0", mem_req_addr_o); end
    checks++; if (drop_cnt_o !== 16'd0) begin errors++; $display("[TB] FAIL reset_drop got %0d expected 0", drop_cnt_o); end
  endtask

  task automatic test_single();
    mem_req_ready_i = 1'b0;
    offer(1'b1, 64'h1039, 1'b0, 64'h0, 1'b0, 64'h0);
    tick();
    clear_cands();
    checks++; if (mem_req_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got %0b expected 1", mem_req_valid_o); end
    checks++; if (mem_req_addr_o !== 64'h1000) begin errors++; $display("[TB] FAIL single_addr got %h expected 1000", mem_req_addr_o); end
    checks++; if (count_o !== 4'd1) begin errors++; $display("[TB] FAIL single_count got %0d expected 1", count_o); end
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    checks++; if (count_o !== 4'd0) begin errors++; $display("[TB] FAIL single_drain got %0d expected 0", count_o); end
  endtask

  task automatic test_dedup();
    offer(1'b1, 64'h2000, 1'b1, 64'h2010, 1'b1, 64'h2040);
    tick();
    clear_cands();
    checks++; if (count_o !== 4'd2) begin errors++; $display("[TB] FAIL dedup_count got %0d expected 2", count_o); end
    checks++; if (mem_req_addr_o !== 64'h2000) begin errors++; $display("[TB] FAIL dedup_head got %h expected 2000", mem_req_addr_o); end
    checks++; if (drop_cnt_o !== 16'd0) begin errors++; $display("[TB] FAIL dedup_drop got %0d expected 0", drop_cnt_o); end
    offer(1'b1, 64'h2005, 1'b0, 64'h0, 1'b0, 64'h0);
    tick();
    clear_cands();
    checks++; if (count_o !== 4'd2) begin errors++; $display("[TB] FAIL dedup_queue_hit got %0d expected 2", count_o); end
    mem_req_ready_i = 1'b1;
    tick();
    checks++; if (mem_req_addr_o !== 64'h2040) begin errors++; $display("[TB] FAIL dedup_second got %h expected 2040", mem_req_addr_o); end
    checks++; if (count_o !== 4'd1) begin errors++; $display("[TB] FAIL dedup_pop_count got %0d expected 1", count_o); end
    offer(1'b1, 64'h2040, 1'b0, 64'h0, 1'b0, 64'h0);
    tick();
    clear_cands();
    mem_req_ready_i = 1'b0;
    checks++; if (count_o !== 4'd0) begin errors++; $display("[TB] FAIL dedup_popping_hit got %0d expected 0", count_o); end
    checks++; if (drop_cnt_o !== 16'd0) begin errors++; $display("[TB] FAIL dedup_popping_drop got %0d expected 0", drop_cnt_o); end
  endtask

  task automatic test_fill();
    logic [3:0]  exp_count [4];
    logic [15:0] exp_drop  [4];
    exp_count[0] = 4'd3; exp_count[1] = 4'd6; exp_count[2] = 4'd8; exp_count[3] = 4'd8;
    exp_drop[0]  = 16'd0; exp_drop[1] = 16'd0; exp_drop[2] = 16'd1; exp_drop[3] = 16'd2;
    mem_req_ready_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c < 3)
        offer(1'b1, 64'h3000 + 64'(c * 3) * 64'h40, 1'b1, 64'h3000 + 64'(c * 3 + 1) * 64'h40,
              1'b1, 64'h3000 + 64'(c * 3 + 2) * 64'h40);
      else
        offer(1'b1, 64'h3240, 1'b0, 64'h0, 1'b0, 64'h0);
      tick();
      clear_cands();
      checks++; if (count_o !== exp_count[c]) begin errors++; $display("[TB] FAIL fill_count[%0d] got %0d expected %0d", c, count_o, exp_count[c]); end
      checks++; if (drop_cnt_o !== exp_drop[c]) begin errors++; $display("[TB] FAIL fill_drop[%0d] got %0d expected %0d", c, drop_cnt_o, exp_drop[c]); end
      checks++; if (mem_req_addr_o !== 64'h3000) begin errors++; $display("[TB] FAIL fill_head[%0d] got %h expected 3000", c, mem_req_addr_o); end
    end
  endtask

  task automatic test_full_pop();
    mem_req_ready_i = 1'b1;
    offer(1'b1, 64'h4000, 1'b0, 64'h0, 1'b0, 64'h0);
    tick();
    mem_req_ready_i = 1'b0;
    checks++; if (count_o !== 4'd7) begin errors++; $display("[TB] FAIL fullpop_count got %0d expected 7", count_o); end
    checks++; if (drop_cnt_o !== 16'd3) begin errors++; $display("[TB] FAIL fullpop_drop got %0d expected 3", drop_cnt_o); end
    checks++; if (mem_req_addr_o !== 64'h3040) begin errors++; $display("[TB] FAIL fullpop_head got %h expected 3040", mem_req_addr_o); end
    tick();
    clear_cands();
    checks++; if (count_o !== 4'd8) begin errors++; $display("[TB] FAIL fullpop_retry_count got %0d expected 8", count_o); end
    checks++; if (drop_cnt_o !== 16'd3) begin errors++; $display("[TB] FAIL fullpop_retry_drop got %0d expected 3", drop_cnt_o); end
  endtask

  task automatic test_flush();
    flush_i = 1'b1;
    offer(1'b1, 64'h5000, 1'b0, 64'h0, 1'b0, 64'h0);
    tick();
    flush_i = 1'b0;
    clear_cands();
    checks++; if (count_o !== 4'd0) begin errors++; $display("[TB] FAIL flush_full_count got %0d expected 0", count_o); end
    offer(1'b1, 64'h5000, 1'b1, 64'h5040, 1'b1, 64'h5080);
    tick();
    offer(1'b1, 64'h50C0, 1'b0, 64'h0, 1'b0, 64'h0);
    tick();
    clear_cands();
    checks++; if (count_o !== 4'd4) begin errors++; $display("[TB] FAIL flush_prefill got %0d expected 4", count_o); end
    flush_i = 1'b1;
    mem_req_ready_i = 1'b1;
    offer(1'b1, 64'h5100, 1'b0, 64'h0, 1'b0, 64'h0);
    tick();
    flush_i = 1'b0;
    mem_req_ready_i = 1'b0;
    clear_cands();
    checks++; if (count_o !== 4'd0) begin errors++; $display("[TB] FAIL flush_count got %0d expected 0", count_o); end
    checks++; if (mem_req_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid got %0b expected 0", mem_req_valid_o); end
    checks++; if (drop_cnt_o !== 16'd3) begin errors++; $display("[TB] FAIL flush_drop got %0d expected 3", drop_cnt_o); end
    tick();
    checks++; if (count_o !== 4'd0) begin errors++; $display("[TB] FAIL flush_no_late_push got %0d expected 0", count_o); end
  endtask

  task automatic test_wrap();
    logic [63:0] exp_addr;
    mem_req_ready_i = 1'b0;
    offer(1'b1, 64'h6000, 1'b1, 64'h6040, 1'b1, 64'h6080);
    tick();
    mem_req_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      offer(1'b1, 64'h6000 + 64'(i + 3) * 64'h40, 1'b0, 64'h0, 1'b0, 64'h0);
      tick();
      exp_addr = 64'h6000 + 64'(i + 1) * 64'h40;
      checks++; if (mem_req_addr_o !== exp_addr) begin errors++; $display("[TB] FAIL wrap_order[%0d] got %h expected %h", i, mem_req_addr_o, exp_addr); end
      checks++; if (count_o !== 4'd3) begin errors++; $display("[TB] FAIL wrap_count[%0d] got %0d expected 3", i, count_o); end
    end
    clear_cands();
    tick();
    checks++; if (mem_req_addr_o !== 64'h6540) begin errors++; $display("[TB] FAIL wrap_drain1 got %h expected 6540", mem_req_addr_o); end
    tick();
    checks++; if (mem_req_addr_o !== 64'h6580) begin errors++; $display("[TB] FAIL wrap_drain2 got %h expected 6580", mem_req_addr_o); end
    tick();
    checks++; if (mem_req_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL wrap_empty got %0b expected 0", mem_req_valid_o); end
    mem_req_ready_i = 1'b0;
  endtask

  task automatic test_enable();
    enable_i = 1'b0;
    offer(1'b1, 64'h7000, 1'b0, 64'h0, 1'b0, 64'h0);
    tick();
    checks++; if (count_o !== 4'd0) begin errors++; $display("[TB] FAIL enable_off_ignore got %0d expected 0", count_o); end
    enable_i = 1'b1;
    tick();
    checks++; if (count_o !== 4'd1) begin errors++; $display("[TB] FAIL enable_on_push got %0d expected 1", count_o); end
    enable_i = 1'b0;
    mem_req_ready_i = 1'b1;
    offer(1'b1, 64'h7040, 1'b0, 64'h0, 1'b0, 64'h0);
    tick();
    clear_cands();
    mem_req_ready_i = 1'b0;
    enable_i = 1'b1;
    checks++; if (count_o !== 4'd0) begin errors++; $display("[TB] FAIL enable_off_drain got %0d expected 0", count_o); end
  endtask

  task automatic test_reset_mid();
    offer(1'b1, 64'h8000, 1'b1, 64'h8040, 1'b0, 64'h0);
    tick();
    checks++; if (count_o !== 4'd2) begin errors++; $display("[TB] FAIL midrst_prefill got %0d expected 2", count_o); end
    rst = 1'b1;
    mem_req_ready_i = 1'b1;
    offer(1'b1, 64'h8080, 1'b0, 64'h0, 1'b0, 64'h0);
    tick();
    rst = 1'b0;
    mem_req_ready_i = 1'b0;
    clear_cands();
    checks++; if (count_o !== 4'd0) begin errors++; $display("[TB] FAIL midrst_count got %0d expected 0", count_o); end
    checks++; if (mem_req_addr_o !== 64'd0) begin errors++; $display("[TB] FAIL midrst_addr got %h expected 0", mem_req_addr_o); end
    checks++; if (drop_cnt_o !== 16'd0) begin errors++; $display("[TB] FAIL midrst_drop got %0d expected 0", drop_cnt_o); end
    tick();
    checks++; if (count_o !== 4'd0) begin errors++; $display("[TB] FAIL midrst_after got %0d expected 0", count_o); end
  endtask

  initial begin
    rst = 1'b1;
    enable_i = 1'b1;
    flush_i = 1'b0;
    mem_req_ready_i = 1'b0;
    pref_addr1_i = '0; pref_addr2_i = '0; pref_addr3_i = '0;
    clear_cands();
    test_reset();
    test_single();
    test_dedup();
    test_fill();
    test_full_pop();
    test_flush();
    test_wrap();
    test_enable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
